sysid_checker: RTL and testbench
================================

SYSID_CHECKER -- requirements
Module: sysid_checker

Interface
REQ-001 Parameter EXPECTED_ID, default 32'h0000_0000: system ID word expected at slave offset 0.
REQ-002 Parameter EXPECTED_TS, default 32'd1512150633: timestamp word expected at slave offset 1.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, range 1..65535: maximum waitrequest cycles per read.
REQ-004 Parameter AUTOSTART, default 1: when 1, a check starts automatically after reset release.
REQ-005 clock  input  1  sole clock; all state on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  single-cycle pulse that requests a (re)check.
REQ-008 address  output  1  Avalon-MM master word address to the sysid slave.
REQ-009 read  output  1  Avalon-MM read strobe.
REQ-010 readdata  input  32  Avalon-MM read data.
REQ-011 waitrequest  input  1  Avalon-MM stall; tie 0 for zero-wait slaves.
REQ-012 busy  output  1  high while a check is in progress.
REQ-013 done  output  1  high once a check has completed or timed out; held until the next check starts.
REQ-014 id_ok  output  1  captured ID equals EXPECTED_ID; valid while done.
REQ-015 ts_ok  output  1  captured timestamp equals EXPECTED_TS; valid while done.
REQ-016 timeout  output  1  a read exceeded TIMEOUT_CYCLES; valid while done.
REQ-017 id_value, ts_value  output  32 each  last captured words.

Function
REQ-018 The FSM SHALL have states IDLE, RD_ID, RD_TS, FIN.
REQ-019 IDLE -> RD_ID on start=1, or in the first cycle after reset release if AUTOSTART=1.
REQ-020 In RD_ID: read=1 and address=0; the transfer completes in the first cycle with read=1 and waitrequest=0; readdata is then captured into id_value; next state RD_TS.
REQ-021 In RD_TS: read=1 and address=1; on completion, readdata is captured into ts_value; next state FIN.
REQ-022 read and address SHALL be registered and held stable while waitrequest=1; read SHALL never be high in IDLE or FIN.
REQ-023 A 16-bit wait counter SHALL clear on entry to RD_ID/RD_TS and increment each cycle with waitrequest=1; when it reaches TIMEOUT_CYCLES with waitrequest still 1, the read SHALL be abandoned (read=0 next cycle), timeout set, and the FSM SHALL go to FIN.
REQ-024 id_ok/ts_ok SHALL be registered compares, updated in the cycle FIN is entered; on timeout, the flag of any word not captured SHALL be 0.
REQ-025 In FIN: done=1, busy=0; FIN -> RD_ID on start=1, clearing done, id_ok, ts_ok and timeout in that transition cycle.
REQ-026 start SHALL be ignored while busy=1.
REQ-027 busy SHALL equal (state is RD_ID or RD_TS).
REQ-028 Minimum latency with waitrequest=0: start accepted at cycle N; reads at N+1 and N+2; done=1 at N+3.

Reset
REQ-029 While reset_n=0: state IDLE; read, busy, done, id_ok, ts_ok, timeout = 0; address = 0; id_value, ts_value, wait counter = 0.
REQ-030 reset_n assertion mid-read SHALL drop read asynchronously; no partial result SHALL survive reset.

Structure
REQ-031 The state encoding and the offset constants (ID = 0, TS = 1) SHALL reside in a shared package, sysid_pkg.
REQ-032 The design SHALL be a single module with no sub-modules; the wait counter is inline.

Verification
REQ-033 Zero-wait slave (offset 0 -> 32'h0000_0000, offset 1 -> 32'd1512150633), AUTOSTART=1 -> done=1 at the 3rd cycle after reset release; id_ok=1, ts_ok=1, timeout=0.
REQ-034 Slave returns 1512150634 at offset 1 -> id_ok=1, ts_ok=0, ts_value=1512150634.
REQ-035 waitrequest high for 5 cycles on each read, TIMEOUT_CYCLES=255 -> read held with address stable throughout; both words captured; done 13 cycles after start.
REQ-036 waitrequest stuck high, TIMEOUT_CYCLES=4 -> read drops after 4 stalled cycles; timeout=1, id_ok=0, ts_ok=0, done=1.
REQ-037 start pulsed during RD_TS -> ignored; start pulsed in FIN -> done clears in the same cycle and a new check runs.
REQ-038 reset_n=0 during a stalled RD_TS -> read=0 immediately; after release with AUTOSTART=0, remains in IDLE with all outputs 0.

Source files
------------

// File: rtl/sysid_pkg.sv
// rtl/sysid_pkg.sv - shared state encoding and slave word offsets for the sysid checker
package sysid_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RD_ID = 2'd1,
      ST_RD_TS = 2'd2,
      ST_FIN   = 2'd3
   } state_e;

   localparam logic OFFSET_ID = 1'b0;
   localparam logic OFFSET_TS = 1'b1;

   function automatic logic is_read_state(input state_e s);
      return (s == ST_RD_ID) || (s == ST_RD_TS);
   endfunction

endpackage

// File: rtl/sysid_checker.sv
// rtl/sysid_checker.sv - reads the sysid slave ID and timestamp words over Avalon-MM and checks them
module sysid_checker
   import sysid_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
   parameter logic [31:0] EXPECTED_TS    = 32'd1512150633,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter bit          AUTOSTART      = 1'b1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        address,
   output logic        read,
   input  logic [31:0] readdata,
   input  logic        waitrequest,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   // A read is abandoned on the stalled cycle that would make the count reach TIMEOUT_CYCLES.
   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_e      state_q, state_d;
   logic        read_q, read_d;
   logic        addr_q, addr_d;
   logic        done_q, done_d;
   logic        id_ok_q, id_ok_d;
   logic        ts_ok_q, ts_ok_d;
   logic        timeout_q, timeout_d;
   logic [31:0] id_value_q, id_value_d;
   logic [31:0] ts_value_q, ts_value_d;
   logic [15:0] wait_q, wait_d;
   logic        auto_q;
   logic        xfer_ok;
   logic        stall_out;

   assign xfer_ok   = read_q && !waitrequest;
   assign stall_out = read_q && waitrequest && (wait_q == WAIT_LAST);

   always_comb begin
      state_d    = state_q;
      done_d     = done_q;
      id_ok_d    = id_ok_q;
      ts_ok_d    = ts_ok_q;
      timeout_d  = timeout_q;
      id_value_d = id_value_q;
      ts_value_d = ts_value_q;
      wait_d     = wait_q;

      case (state_q)
         ST_IDLE, ST_FIN: begin
            if (start || auto_q) begin
               state_d   = ST_RD_ID;
               wait_d    = 16'd0;
               done_d    = 1'b0;
               id_ok_d   = 1'b0;
               ts_ok_d   = 1'b0;
               timeout_d = 1'b0;
            end
         end
         ST_RD_ID: begin
            if (xfer_ok) begin
               id_value_d = readdata;
               state_d    = ST_RD_TS;
               wait_d     = 16'd0;
            end else if (stall_out) begin
               state_d   = ST_FIN;
               done_d    = 1'b1;
               timeout_d = 1'b1;
               id_ok_d   = 1'b0;
               ts_ok_d   = 1'b0;
            end else if (waitrequest) begin
               wait_d = wait_q + 16'd1;
            end
         end
         ST_RD_TS: begin
            if (xfer_ok) begin
               ts_value_d = readdata;
               state_d    = ST_FIN;
               done_d     = 1'b1;
               id_ok_d    = (id_value_q == EXPECTED_ID);
               ts_ok_d    = (readdata == EXPECTED_TS);
            end else if (stall_out) begin
               // The ID word was captured, so its verdict still stands.
               state_d   = ST_FIN;
               done_d    = 1'b1;
               timeout_d = 1'b1;
               id_ok_d   = (id_value_q == EXPECTED_ID);
               ts_ok_d   = 1'b0;
            end else if (waitrequest) begin
               wait_d = wait_q + 16'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      read_d = is_read_state(state_d);
      addr_d = (state_d == ST_RD_TS) ? OFFSET_TS : OFFSET_ID;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         read_q     <= 1'b0;
         addr_q     <= OFFSET_ID;
         done_q     <= 1'b0;
         id_ok_q    <= 1'b0;
         ts_ok_q    <= 1'b0;
         timeout_q  <= 1'b0;
         id_value_q <= 32'd0;
         ts_value_q <= 32'd0;
         wait_q     <= 16'd0;
         auto_q     <= AUTOSTART;
      end else begin
         state_q    <= state_d;
         read_q     <= read_d;
         addr_q     <= addr_d;
         done_q     <= done_d;
         id_ok_q    <= id_ok_d;
         ts_ok_q    <= ts_ok_d;
         timeout_q  <= timeout_d;
         id_value_q <= id_value_d;
         ts_value_q <= ts_value_d;
         wait_q     <= wait_d;
         auto_q     <= 1'b0;
      end
   end

   assign read     = read_q;
   assign address  = addr_q;
   assign busy     = is_read_state(state_q);
   assign done     = done_q;
   assign id_ok    = id_ok_q;
   assign ts_ok    = ts_ok_q;
   assign timeout  = timeout_q;
   assign id_value = id_value_q;
   assign ts_value = ts_value_q;

endmodule

// File: tb/tb_sysid_checker.sv
// tb/tb_sysid_checker.sv - randomized self-checking bench for sysid_checker
module tb_sysid_checker;

   localparam int          T_A      = 255;
   localparam int          T_B      = 4;
   localparam logic [31:0] EXP_ID_A = 32'h0000_0000;
   localparam logic [31:0] EXP_ID_B = 32'hCAFE_0001;
   localparam logic [31:0] EXP_TS   = 32'd1512150633;
   localparam int          STUCK    = 100000;

   logic clock;
   logic rst_a_n, rst_b_n, start_a, start_b;
   logic waitrequest;
   logic [31:0] readdata;

   logic a_address, a_read, a_busy, a_done, a_id_ok, a_ts_ok, a_timeout;
   logic [31:0] a_id_value, a_ts_value;
   logic b_address, b_read, b_busy, b_done, b_id_ok, b_ts_ok, b_timeout;
   logic [31:0] b_id_value, b_ts_value;

   sysid_checker #(
      .EXPECTED_ID(EXP_ID_A), .EXPECTED_TS(EXP_TS), .TIMEOUT_CYCLES(T_A), .AUTOSTART(1'b1)
   ) dut_a (
      .clock(clock), .reset_n(rst_a_n), .start(start_a),
      .address(a_address), .read(a_read), .readdata(readdata), .waitrequest(waitrequest),
      .busy(a_busy), .done(a_done), .id_ok(a_id_ok), .ts_ok(a_ts_ok), .timeout(a_timeout),
      .id_value(a_id_value), .ts_value(a_ts_value)
   );

   sysid_checker #(
      .EXPECTED_ID(EXP_ID_B), .EXPECTED_TS(EXP_TS), .TIMEOUT_CYCLES(T_B), .AUTOSTART(1'b0)
   ) dut_b (
      .clock(clock), .reset_n(rst_b_n), .start(start_b),
      .address(b_address), .read(b_read), .readdata(readdata), .waitrequest(waitrequest),
      .busy(b_busy), .done(b_done), .id_ok(b_id_ok), .ts_ok(b_ts_ok), .timeout(b_timeout),
      .id_value(b_id_value), .ts_value(b_ts_value)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Observation mux: which DUT the current check looks at.
   logic sel;
   wire        s_read     = sel ? b_read     : a_read;
   wire        s_address  = sel ? b_address  : a_address;
   wire        s_busy     = sel ? b_busy     : a_busy;
   wire        s_done     = sel ? b_done     : a_done;
   wire        s_id_ok    = sel ? b_id_ok    : a_id_ok;
   wire        s_ts_ok    = sel ? b_ts_ok    : a_ts_ok;
   wire        s_timeout  = sel ? b_timeout  : a_timeout;
   wire [31:0] s_id_value = sel ? b_id_value : a_id_value;
   wire [31:0] s_ts_value = sel ? b_ts_value : a_ts_value;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Slave: each new read transaction stalls for a programmed number of cycles, then returns its word.
   int          id_stall, ts_stall, sl_left;
   logic [31:0] id_word, ts_word;
   logic        sl_r, sl_a, sl_prev_r, sl_prev_a;

   initial begin
      waitrequest = 1'b0;
      readdata    = 32'd0;
      sl_left     = 0;
      sl_prev_r   = 1'b0;
      sl_prev_a   = 1'b0;
   end

   always @(negedge clock) begin
      sl_r = a_read | b_read;
      sl_a = a_read ? a_address : b_address;
      if (sl_r && !(sl_prev_r && (sl_prev_a == sl_a)))
         sl_left = sl_a ? ts_stall : id_stall;
      if (sl_r && sl_left > 0) begin
         waitrequest = 1'b1;
         readdata    = $urandom;
         sl_left     = sl_left - 1;
      end else begin
         waitrequest = 1'b0;
         readdata    = sl_a ? ts_word : id_word;
      end
      sl_prev_r = sl_r;
      sl_prev_a = sl_a;
   end

   logic [31:0] exp_idv [2];
   logic [31:0] exp_tsv [2];

   // Reference: each read occupies min(stalls+1, T) cycles; stalls >= T means that read times out.
   task automatic run_check(input bit which, input bit autostart, input int s_id, input int s_ts,
                            input logic [31:0] w_id, input logic [31:0] w_ts, input int poke_k);
      int t, a0_exp, a1_exp, lat_exp, a0, a1, lat, bad_busy;
      bit id_to, ts_to, got;
      logic [31:0] e_id, exp_idok, exp_tsok;
      t        = which ? T_B : T_A;
      e_id     = which ? EXP_ID_B : EXP_ID_A;
      id_stall = s_id;
      ts_stall = s_ts;
      id_word  = w_id;
      ts_word  = w_ts;
      sel      = which;
      id_to    = (s_id >= t);
      ts_to    = !id_to && (s_ts >= t);
      a0_exp   = id_to ? t : s_id + 1;
      a1_exp   = id_to ? 0 : (ts_to ? t : s_ts + 1);
      lat_exp  = 1 + a0_exp + a1_exp;
      exp_idok = {31'd0, !id_to && (w_id == e_id)};
      exp_tsok = {31'd0, !id_to && !ts_to && (w_ts == EXP_TS)};
      if (!id_to) exp_idv[which] = w_id;
      if (!id_to && !ts_to) exp_tsv[which] = w_ts;

      @(negedge clock);
      if (autostart) rst_a_n = 1'b1;
      else if (which) start_b = 1'b1;
      else start_a = 1'b1;
      a0 = 0; a1 = 0; lat = 0; bad_busy = 0; got = 1'b0;
      for (int k = 1; k <= 1000 && !got; k++) begin
         @(negedge clock);
         start_a = !which && (k == poke_k);
         start_b = which && (k == poke_k);
         if (k == 1) check_eq("done_clear", {31'd0, s_done}, 32'd0);
         if (s_busy !== s_read) bad_busy++;
         if (s_read && !s_address) a0++;
         if (s_read && s_address) a1++;
         if (s_done) begin
            got = 1'b1;
            lat = k;
         end
      end
      start_a = 1'b0;
      start_b = 1'b0;
      check_eq("done_seen", {31'd0, got}, 32'd1);
      check_eq("latency", 32'(lat), 32'(lat_exp));
      check_eq("id_read_cycles", 32'(a0), 32'(a0_exp));
      check_eq("ts_read_cycles", 32'(a1), 32'(a1_exp));
      check_eq("busy_vs_read", 32'(bad_busy), 32'd0);
      check_eq("fin_idle_bus", {30'd0, s_busy, s_read}, 32'd0);
      check_eq("timeout", {31'd0, s_timeout}, {31'd0, id_to || ts_to});
      check_eq("id_ok", {31'd0, s_id_ok}, exp_idok);
      check_eq("ts_ok", {31'd0, s_ts_ok}, exp_tsok);
      check_eq("id_value", s_id_value, exp_idv[which]);
      check_eq("ts_value", s_ts_value, exp_tsv[which]);
      repeat (2) @(negedge clock);
   endtask

   function automatic logic [31:0] rand_word(input logic [31:0] good);
      case ($urandom_range(0, 2))
         0:       return good;
         1:       return good + 32'd1;
         default: return $urandom;
      endcase
   endfunction

   int s1, s2;

   initial begin
      rst_a_n = 1'b0; rst_b_n = 1'b0; start_a = 1'b0; start_b = 1'b0; sel = 1'b0;
      id_stall = 0; ts_stall = 0; id_word = 32'd0; ts_word = 32'd0;
      exp_idv[0] = 32'd0; exp_idv[1] = 32'd0; exp_tsv[0] = 32'd0; exp_tsv[1] = 32'd0;
      repeat (3) @(negedge clock);
      for (int w = 0; w < 2; w++) begin
         sel = w[0];
         #1;
         check_eq("rst_flags", {25'd0, s_read, s_address, s_busy, s_done, s_id_ok, s_ts_ok, s_timeout}, 32'd0);
         check_eq("rst_id_value", s_id_value, 32'd0);
         check_eq("rst_ts_value", s_ts_value, 32'd0);
      end

      // Without autostart the checker must stay idle after release.
      rst_b_n = 1'b1;
      repeat (6) @(negedge clock);
      sel = 1'b1;
      check_eq("b_noauto_idle", {28'd0, s_read, s_busy, s_done, s_timeout}, 32'd0);

      run_check(1'b0, 1'b1, 0, 0, 32'h0000_0000, EXP_TS, 0);
      run_check(1'b0, 1'b0, 0, 0, 32'h0000_0000, EXP_TS + 32'd1, 0);
      run_check(1'b0, 1'b0, 5, 5, rand_word(EXP_ID_A), rand_word(EXP_TS), 0);
      run_check(1'b0, 1'b0, 0, 3, EXP_ID_A, EXP_TS, 2);
      for (int i = 0; i < 8; i++) begin
         s1 = $urandom_range(0, 7);
         s2 = $urandom_range(0, 7);
         if (s1 == 7) s1 = STUCK;
         if (s2 == 7) s2 = STUCK;
         run_check(1'b0, 1'b0, s1, s2, rand_word(EXP_ID_A), rand_word(EXP_TS), $urandom_range(0, 4));
      end

      run_check(1'b1, 1'b0, STUCK, 0, EXP_ID_B, EXP_TS, 0);
      run_check(1'b1, 1'b0, 3, 3, EXP_ID_B, EXP_TS, 0);
      run_check(1'b1, 1'b0, 0, STUCK, EXP_ID_B, EXP_TS, 0);
      for (int i = 0; i < 12; i++) begin
         s1 = $urandom_range(0, 6);
         s2 = $urandom_range(0, 6);
         run_check(1'b1, 1'b0, s1, s2, rand_word(EXP_ID_B), rand_word(EXP_TS), $urandom_range(0, 3));
      end

      // Reset asserted while the timestamp read is stalled.
      sel = 1'b1; id_stall = 0; ts_stall = STUCK; id_word = EXP_ID_B; ts_word = EXP_TS;
      @(negedge clock);
      start_b = 1'b1;
      @(negedge clock);
      start_b = 1'b0;
      repeat (2) @(negedge clock);
      check_eq("pre_rst_rd_ts", {30'd0, s_read, s_address}, 32'd3);
      rst_b_n = 1'b0;
      #1;
      check_eq("async_read_drop", {31'd0, s_read}, 32'd0);
      check_eq("rst_mid_flags", {25'd0, s_read, s_address, s_busy, s_done, s_id_ok, s_ts_ok, s_timeout}, 32'd0);
      check_eq("rst_mid_id_value", s_id_value, 32'd0);
      @(negedge clock);
      rst_b_n = 1'b1;
      repeat (6) @(negedge clock);
      check_eq("post_rst_flags", {25'd0, s_read, s_address, s_busy, s_done, s_id_ok, s_ts_ok, s_timeout}, 32'd0);
      check_eq("post_rst_id_value", s_id_value, 32'd0);
      check_eq("post_rst_ts_value", s_ts_value, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
